// File: rtl/mandel_iter.sv
// Mandelbrot escape-time iterator for one pixel.
// Sequences three products per iteration through an external multiplier.
module mandel_iter #(
    parameter int FRAC = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic signed [7:0] i_cr,
    input  logic signed [7:0] i_ci,
    input  logic [7:0]        i_max_iter,
    output logic signed [7:0] o_mul_x,
    output logic signed [7:0] o_mul_y,
    output logic              o_mul_start,
    input  logic signed [15:0] i_mul_out,
    input  logic              i_mul_finished,
    output logic              o_busy,
    output logic              o_done,
    output logic [7:0]        o_iter_count,
    output logic              o_escaped
);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL_XX, S_MUL_YY, S_MUL_XY, S_UPDATE, S_DONE
    } state_t;

    // |z|^2 threshold of 4.0 in the product format
    localparam logic signed [16:0] LP_ESC = 17'(4 << (2 * FRAC));

    state_t r_state;
    state_t w_next;
    logic   r_first;
    logic   w_enter_mul;

    logic signed [7:0]  r_cr, r_ci, r_zr, r_zi;
    logic [7:0]         r_max, r_iter;
    logic               r_escaped;
    logic signed [15:0] r_xx, r_yy, r_xy;

    logic signed [16:0] w_sum;
    logic               w_escape;
    logic signed [17:0] w_diff, w_xye, w_crx, w_cix;
    logic signed [17:0] w_zr_n, w_zi_n;
    logic [7:0]         w_iter_inc;

    function automatic logic [7:0] f_sat8(input logic signed [17:0] v);
        if (v > 18'sd127)
            return 8'h7F;
        else if (v < -18'sd128)
            return 8'h80;
        else
            return v[7:0];
    endfunction

    assign w_sum      = {r_xx[15], r_xx} + {r_yy[15], r_yy};
    assign w_escape   = (w_sum > LP_ESC);
    assign w_diff     = {{2{r_xx[15]}}, r_xx} - {{2{r_yy[15]}}, r_yy};
    assign w_xye      = {{2{r_xy[15]}}, r_xy};
    assign w_crx      = {{10{r_cr[7]}}, r_cr};
    assign w_cix      = {{10{r_ci[7]}}, r_ci};
    assign w_zr_n     = (w_diff >>> FRAC) + w_crx;
    assign w_zi_n     = (w_xye >>> (FRAC - 1)) + w_cix;
    assign w_iter_inc = r_iter + 8'd1;

    assign w_enter_mul = (w_next != r_state) &&
                         (w_next inside {S_MUL_XX, S_MUL_YY, S_MUL_XY});

    // state register plus first-cycle flag for the multiplier request
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= w_enter_mul;
        end
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:
                if (i_start)
                    w_next = (i_max_iter == 8'd0) ? S_DONE : S_MUL_XX;
            S_MUL_XX:
                if (i_mul_finished) w_next = S_MUL_YY;
            S_MUL_YY:
                if (i_mul_finished) w_next = S_MUL_XY;
            S_MUL_XY:
                if (i_mul_finished) w_next = S_UPDATE;
            S_UPDATE:
                if (w_escape || (w_iter_inc == r_max))
                    w_next = S_DONE;
                else
                    w_next = S_MUL_XX;
            S_DONE:
                w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
    end

    // outputs decoded from state; operands are zero outside MUL states
    always_comb begin
        o_mul_x     = 8'sd0;
        o_mul_y     = 8'sd0;
        o_mul_start = 1'b0;
        o_busy      = (r_state != S_IDLE);
        o_done      = (r_state == S_DONE);
        unique case (r_state)
            S_MUL_XX: begin
                o_mul_x     = r_zr;
                o_mul_y     = r_zr;
                o_mul_start = r_first;
            end
            S_MUL_YY: begin
                o_mul_x     = r_zi;
                o_mul_y     = r_zi;
                o_mul_start = r_first;
            end
            S_MUL_XY: begin
                o_mul_x     = r_zr;
                o_mul_y     = r_zi;
                o_mul_start = r_first;
            end
            default: ;
        endcase
    end

    assign o_iter_count = r_iter;
    assign o_escaped    = r_escaped;

    // datapath: operand latch, product capture and z update
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cr      <= '0;
            r_ci      <= '0;
            r_zr      <= '0;
            r_zi      <= '0;
            r_max     <= '0;
            r_iter    <= '0;
            r_escaped <= 1'b0;
            r_xx      <= '0;
            r_yy      <= '0;
            r_xy      <= '0;
        end else begin
            case (r_state)
                S_IDLE:
                    if (i_start) begin
                        r_cr      <= i_cr;
                        r_ci      <= i_ci;
                        r_max     <= i_max_iter;
                        r_zr      <= '0;
                        r_zi      <= '0;
                        r_iter    <= '0;
                        r_escaped <= 1'b0;
                    end
                S_MUL_XX:
                    if (i_mul_finished) r_xx <= i_mul_out;
                S_MUL_YY:
                    if (i_mul_finished) r_yy <= i_mul_out;
                S_MUL_XY:
                    if (i_mul_finished) r_xy <= i_mul_out;
                S_UPDATE:
                    if (w_escape) begin
                        r_escaped <= 1'b1;
                    end else begin
                        r_zr   <= f_sat8(w_zr_n);
                        r_zi   <= f_sat8(w_zi_n);
                        r_iter <= w_iter_inc;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mandel_iter.md
MANDEL_ITER -- requirements
Module: mandel_iter

Interface
REQ-001 The block SHALL have parameter FRAC, default 5, giving the fraction bits of the signed 8-bit coordinate format (Q3.5 at default).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  begin one pixel; sampled only in IDLE.
REQ-005 cr, ci  input  8 each  signed constant c; latched on accepted start.
REQ-006 max_iter  input  8  unsigned iteration limit; latched on accepted start.
REQ-007 mul_x, mul_y  output  8 each  signed operands to the bit-serial multiplier; held stable from mul_start until mul_finished.
REQ-008 mul_start  output  1  one-cycle request pulse to the multiplier.
REQ-009 mul_out  input  16  signed product, Q6.10 at default; valid in the cycle mul_finished=1.
REQ-010 mul_finished  input  1  one-cycle completion pulse from the multiplier.
REQ-011 busy  output  1  high from the accepted start until the cycle after done.
REQ-012 done  output  1  one-cycle pulse when iter_count and escaped are final.
REQ-013 iter_count  output  8  completed z updates.
REQ-014 escaped  output  1  1 when |z|^2 > 4.0 was detected.

Function
REQ-015 The FSM SHALL have states IDLE, MUL_XX, MUL_YY, MUL_XY, UPDATE and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch cr, ci and max_iter, clear zr, zi and iter, and go to DONE if max_iter=0, otherwise to MUL_XX.
REQ-017 In the first cycle of each MUL state, the block SHALL assert mul_start for exactly one cycle, with operands (zr,zr), (zi,zi) and (zr,zi) for MUL_XX, MUL_YY and MUL_XY.
REQ-018 Each MUL state SHALL wait for mul_finished, capture mul_out as xx, yy or xy (16-bit) in that cycle, and then advance to MUL_YY, MUL_XY and UPDATE in that order.
REQ-019 mul_finished arriving in IDLE, UPDATE or DONE SHALL be ignored.
REQ-020 UPDATE SHALL last one cycle and compute the escape test as the 17-bit signed sum xx+yy > (4 << 2*FRAC); a sum exactly equal to 4.0 SHALL NOT escape.
REQ-021 On escape, UPDATE SHALL set escaped=1, leave iter unchanged and go to DONE.
REQ-022 Otherwise, UPDATE SHALL compute zr' = sat8(((xx-yy) >>> FRAC) + cr) and zi' = sat8((xy >>> (FRAC-1)) + ci), using arithmetic shifts and at least 18-bit intermediates.
REQ-023 sat8 SHALL clamp to the range [-128, 127].
REQ-024 After a non-escaping UPDATE, the block SHALL increment iter and go to DONE with escaped=0 if the new iter equals max_iter, else go to MUL_XX.
REQ-025 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-026 iter_count SHALL equal iter, and iter_count and escaped SHALL hold their values until the next accepted start.
REQ-027 start while busy=1 SHALL be ignored, with no effect on state or outputs.
REQ-028 Per-iteration latency SHALL be 3*(Lm+1)+1 cycles, where Lm is the cycle count from mul_start to mul_finished.
REQ-029 There SHALL be exactly three mul_start pulses per completed or escaping iteration, and none while in IDLE or DONE.

Reset
REQ-030 rst=1 SHALL force, on the next edge, state=IDLE and busy=0, done=0, mul_start=0, mul_x=0, mul_y=0, iter_count=0 and escaped=0.
REQ-031 rst SHALL take priority over start and mul_finished in the same cycle.
REQ-032 Reset mid-operation SHALL abandon the pixel, and the system SHALL reset the attached multiplier with the same rst so that no stale mul_finished is delivered.
REQ-033 The first start accepted after reset SHALL behave identically to the first start after power-up.

Verification
REQ-034 The bench SHALL use a signed multiplier model with Lm=9, and SHALL cover at least the following directed scenarios.
REQ-035 cr=0x00, ci=0x00, max_iter=20 -> done pulse with iter_count=20, escaped=0, and 60 mul_start pulses.
REQ-036 cr=0x60 (3.0), ci=0x00, max_iter=50 -> z1=(3.0,0), escape at the second UPDATE, giving iter_count=1, escaped=1, and done 2*31 cycles after start acceptance plus the DONE cycle.
REQ-037 cr=0xC0 (-2.0), ci=0x00, max_iter=10 -> z held at 2.0 with |z|^2 exactly 4.0 never escaping, giving iter_count=10, escaped=0.
REQ-038 max_iter=0 with any c -> done one cycle after start, iter_count=0, escaped=0, and no mul_start.
REQ-039 cr=0x7F, ci=0x7F -> z1=(0x7F,0x7F) and escape, giving iter_count=1, escaped=1; a further check with z forced large confirms sat8 clamps zr' to 0x7F or 0x80 rather than wrapping.
REQ-040 rst asserted during MUL_XY of iteration 3 -> next cycle busy=0, mul_start=0, iter_count=0; start pulses during busy are ignored; a following start with c=0, max_iter=5 yields iter_count=5, escaped=0.
